// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encodings,
// timeout-error read data and default timeout length.
package bus_arbiter_rr_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Read data returned to a master whose transaction was terminated by timeout
   localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

   // Default number of BUSY cycles without a slave ack before forced termination
   localparam int ARB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/bus_arbiter_rr_rr_picker.sv
// rr_picker: combinational round-robin selector. Returns a one-hot grant for
// the first requester at or after ptr_i (wrapping N-1 -> 0) plus an any flag.
// Kept standalone so interrupt and priority logic can reuse it.
module rr_picker #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic          any_o
);

   // Walk the requesters starting at the pointer, keep the first hit
   always_comb begin
      logic found;
      int   idx;
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin arbiter in front of a single memory
// bus slave. One transaction in flight; an idle cycle separates grants.
// Optional feature macro: ARB_TIMEOUT_EN -- terminates a BUSY transaction
// with o_err and ARB_ERR_DATA after TIMEOUT_CYCLES cycles without i_ack.
module bus_arbiter_rr
   import bus_arbiter_rr_pkg::*;
#(
   parameter int N_MASTERS      = 4,
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_MASTERS-1:0]   i_bus_en,
   input  logic [N_MASTERS-1:0]   i_wr_rd,
   input  logic [N_MASTERS*XLEN-1:0] i_wr_data,
   input  logic [N_MASTERS*XLEN-1:0] i_addr,
   input  logic [N_MASTERS*3-1:0] i_size,
   output logic [N_MASTERS-1:0]   o_ack,
   output logic [XLEN-1:0]        o_rd_data,
   output logic                   o_err,
   output logic [N_MASTERS-1:0]   o_grant,
   input  logic                   i_ack,
   input  logic [XLEN-1:0]        i_rd_data,
   output logic                   o_bus_en,
   output logic                   o_wr_rd,
   output logic [XLEN-1:0]        o_wr_data,
   output logic [XLEN-1:0]        o_addr,
   output logic [2:0]             o_size
);

   localparam int PW = $clog2(N_MASTERS);

   if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("bus_arbiter_rr: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   arb_state_e           state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;

   logic [N_MASTERS-1:0] pick_grant;
   logic                 pick_any;
   logic [PW-1:0]        gidx;
   logic [PW-1:0]        ptr_next;
   logic                 busy;
   logic                 owner_req;
   logic                 ack_ok;
   logic                 to_hit;
   logic                 done;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]        cnt_q, cnt_d;
`endif

   rr_picker #(
      .N  (N_MASTERS),
      .PW (PW)
   ) u_picker (
      .req_i   (i_bus_en),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .any_o   (pick_any)
   );

   // Binary index of the current owner, used to advance the pointer
   always_comb begin
      gidx = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
         if (grant_q[m]) gidx = PW'(m);
      end
   end

   assign ptr_next  = (int'(gidx) == N_MASTERS - 1) ? '0 : gidx + PW'(1);
   assign busy      = (state_q == ARB_BUSY);
   // Owner still holding its request; losing it mid-transaction aborts silently
   assign owner_req = |(i_bus_en & grant_q);
   assign ack_ok    = busy && !i_rst && owner_req && i_ack;

`ifdef ARB_TIMEOUT_EN
   // Slave ack in the same cycle as the timeout takes precedence
   assign to_hit = busy && !i_rst && owner_req && !i_ack &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   assign done = ack_ok || to_hit;

   // State, pointer, owner and timeout counter registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next-state logic plus slave-side mux and master-side completion outputs
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      o_bus_en  = 1'b0;
      o_wr_rd   = 1'b0;
      o_wr_data = '0;
      o_addr    = '0;
      o_size    = '0;
      o_ack     = '0;
      o_rd_data = '0;
      o_err     = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_d = pick_grant;
               state_d = ARB_BUSY;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ARB_BUSY: begin
            if (!owner_req) begin
               // protocol violation: drop the transaction, keep the pointer
               state_d = ARB_IDLE;
               grant_d = '0;
            end else if (done) begin
               state_d = ARB_IDLE;
               grant_d = '0;
               ptr_d   = ptr_next;
            end else begin
`ifdef ARB_TIMEOUT_EN
               cnt_d   = cnt_q + CW'(1);
`endif
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (busy) begin
         o_bus_en = 1'b1;
         for (int m = 0; m < N_MASTERS; m++) begin
            if (grant_q[m]) begin
               o_wr_rd   = o_wr_rd   | i_wr_rd[m];
               o_wr_data = o_wr_data | i_wr_data[m*XLEN +: XLEN];
               o_addr    = o_addr    | i_addr[m*XLEN +: XLEN];
               o_size    = o_size    | i_size[m*3 +: 3];
            end
         end
      end

      if (ack_ok) begin
         o_ack     = grant_q;
         o_rd_data = i_rd_data;
      end else if (to_hit) begin
         o_ack     = grant_q;
         o_rd_data = XLEN'(ARB_ERR_DATA);
         o_err     = 1'b1;
      end
   end

   assign o_grant = grant_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios followed by
// randomized masters/slave, all compared cycle by cycle against a
// transaction-level reference model (owner, pointer, cycles-in-flight).
module tb_bus_arbiter_rr;

   localparam int N  = 4;
   localparam int XL = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            i_rst;
   logic [N-1:0]    i_bus_en, i_wr_rd;
   logic [N*XL-1:0] i_wr_data, i_addr;
   logic [N*3-1:0]  i_size;
   logic [N-1:0]    o_ack, o_grant;
   logic [XL-1:0]   o_rd_data;
   logic            o_err;
   logic            i_ack;
   logic [XL-1:0]   i_rd_data;
   logic            o_bus_en, o_wr_rd;
   logic [XL-1:0]   o_wr_data, o_addr;
   logic [2:0]      o_size;

   bus_arbiter_rr #(.N_MASTERS(N), .XLEN(XL), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_bus_en(i_bus_en), .i_wr_rd(i_wr_rd),
      .i_wr_data(i_wr_data), .i_addr(i_addr), .i_size(i_size),
      .o_ack(o_ack), .o_rd_data(o_rd_data), .o_err(o_err), .o_grant(o_grant),
      .i_ack(i_ack), .i_rd_data(i_rd_data), .o_bus_en(o_bus_en),
      .o_wr_rd(o_wr_rd), .o_wr_data(o_wr_data), .o_addr(o_addr), .o_size(o_size)
   );

   // master agents
   bit          pend [N];
   bit          cool [N];
   logic        m_wr [N];
   logic [31:0] m_addr [N];
   logic [31:0] m_data [N];
   logic [2:0]  m_size [N];
   int          auto_p, viol_p, ack_p, ack_mode;
   logic        ack_r, rst_r;
   logic [31:0] rd_r;

   // reference model: is a transaction in flight, who owns it, rotation pointer
   bit mb;
   int mown, mptr, mage;

   int n_chk = 0, n_fail = 0;
   int order_q [$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic new_req(input int m, input bit wr);
      pend[m]   = 1'b1;
      m_wr[m]   = wr;
      m_addr[m] = $urandom;
      m_data[m] = $urandom;
      m_size[m] = 3'($urandom_range(0, 5));
   endtask

   task automatic step();
      logic [N-1:0] e_ack, e_grant;
      logic [31:0]  e_rd, e_addr, e_wd;
      logic [2:0]   e_sz;
      logic         e_en, e_wr, e_err;
      bit           viol, done, anyp;
      @(negedge clk);
      for (int m = 0; m < N; m++) begin
         if (cool[m]) cool[m] = 1'b0;
         else if (!pend[m] && $urandom_range(0, 99) < auto_p) new_req(m, 1'($urandom));
      end
      if (mb && pend[mown] && viol_p > 0 && $urandom_range(0, 99) < viol_p) pend[mown] = 1'b0;
      if (ack_mode == 0) begin
         ack_r = ($urandom_range(0, 99) < ack_p);
         rd_r  = $urandom;
      end else if (ack_mode == 1) begin
         ack_r = mb && (mage >= 1);
         rd_r  = $urandom;
      end
      for (int m = 0; m < N; m++) begin
         i_bus_en[m]          = pend[m];
         i_wr_rd[m]           = m_wr[m];
         i_wr_data[m*XL +: XL] = m_data[m];
         i_addr[m*XL +: XL]    = m_addr[m];
         i_size[m*3 +: 3]      = m_size[m];
      end
      i_ack     = ack_r;
      i_rd_data = rd_r;
      i_rst     = rst_r;
      #1;
      e_ack = '0; e_grant = '0; e_rd = '0; e_addr = '0; e_wd = '0; e_sz = '0;
      e_en = 1'b0; e_wr = 1'b0; e_err = 1'b0; viol = 1'b0; done = 1'b0;
      if (mb) begin
         e_en = 1'b1;
         e_grant[mown] = 1'b1;
         e_wr = m_wr[mown]; e_addr = m_addr[mown]; e_wd = m_data[mown]; e_sz = m_size[mown];
         if (!rst_r) begin
            if (!pend[mown]) viol = 1'b1;
            else if (ack_r) begin
               done = 1'b1; e_ack[mown] = 1'b1; e_rd = rd_r;
            end
`ifdef ARB_TIMEOUT_EN
            else if (mage == TO - 1) begin
               done = 1'b1; e_ack[mown] = 1'b1; e_rd = 32'hDEAD_BEEF; e_err = 1'b1;
            end
`endif
         end
      end
      chk("bus_en", o_bus_en, e_en);
      chk("grant", o_grant, e_grant);
      chk("ack", o_ack, e_ack);
      chk("rd_data", o_rd_data, e_rd);
      chk("err", o_err, e_err);
      chk("wr_rd", o_wr_rd, e_wr);
      chk("addr", o_addr, e_addr);
      chk("wr_data", o_wr_data, e_wd);
      chk("size", o_size, e_sz);
      if (o_ack != 0) order_q.push_back($clog2(o_ack));
      if (rst_r) begin
         mb = 1'b0; mptr = 0;
      end else if (mb) begin
         if (viol) mb = 1'b0;
         else if (done) begin
            mb = 1'b0; mptr = (mown + 1) % N;
            pend[mown] = 1'b0; cool[mown] = 1'b1;
         end else mage++;
      end else begin
         anyp = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!anyp && pend[(mptr + k) % N]) begin
               anyp = 1'b1; mown = (mptr + k) % N;
            end
         end
         if (anyp) begin mb = 1'b1; mage = 0; end
      end
   endtask

   task automatic drop_all();
      for (int m = 0; m < N; m++) begin pend[m] = 1'b0; cool[m] = 1'b0; end
   endtask

   initial begin
      for (int m = 0; m < N; m++) begin
         pend[m] = 0; cool[m] = 0; m_wr[m] = 0; m_addr[m] = 0; m_data[m] = 0; m_size[m] = 0;
      end
      auto_p = 0; viol_p = 0; ack_p = 30; ack_mode = 2; ack_r = 0; rd_r = 0; rst_r = 1;
      mb = 0; mown = 0; mptr = 0; mage = 0;
      i_rst = 1; i_bus_en = '0; i_wr_rd = '0; i_wr_data = '0; i_addr = '0; i_size = '0;
      i_ack = 0; i_rd_data = '0;
      repeat (2) @(posedge clk);
      step();
      chk("rst_grant", o_grant, 0);
      chk("rst_bus_en", o_bus_en, 0);
      rst_r = 0;

      // single master m2 read, slave answers in the third BUSY cycle
      new_req(2, 1'b0);
      step();
      step(); chk("t1_bus_en", o_bus_en, 1);
      step(); chk("t2_bus_en", o_bus_en, 1);
      ack_r = 1; rd_r = 32'h1234_5678;
      step(); chk("t3_ack", o_ack, 4'b0100); chk("t3_rd", o_rd_data, 32'h1234_5678);
      ack_r = 0; rd_r = 0;
      step(); chk("t4_bus_en", o_bus_en, 0);

      // pointer now 3: m0 and m3 compete -> m3 first, then m0
      new_req(0, 1'b1); new_req(3, 1'b0);
      step();
      step(); chk("p3_first", o_grant, 4'b1000);
      ack_r = 1; step(); ack_r = 0;
      step();
      step(); chk("p3_second", o_grant, 4'b0001);
      ack_r = 1; step(); ack_r = 0;

      // pointer 1: granted m1 drops its request without ack
      new_req(1, 1'b0);
      step();
      step(); chk("drop_grant", o_grant, 4'b0010);
      pend[1] = 0;
      step(); chk("drop_no_ack", o_ack, 0);
      step(); chk("drop_bus_en", o_bus_en, 0); chk("drop_ack2", o_ack, 0);
      new_req(1, 1'b1); new_req(2, 1'b1);
      step();
      step(); chk("drop_ptr_kept", o_grant, 4'b0010);
      ack_r = 1; step(); ack_r = 0;
      step();

      // reset in the middle of a BUSY transaction
      step(); chk("pre_rst_grant", o_grant, 4'b0100);
      rst_r = 1; drop_all();
      step();
      rst_r = 0;
      step(); chk("rst_mid_bus_en", o_bus_en, 0); chk("rst_mid_grant", o_grant, 0);
      ack_r = 1;
      step(); chk("late_ack", o_ack, 0);
      ack_r = 0;

      // fairness: everyone requests continuously
      order_q.delete();
      for (int m = 0; m < N; m++) new_req(m, 1'($urandom));
      ack_mode = 1; auto_p = 100;
      repeat (20) step();
      auto_p = 0;
      chk("fair_count", (order_q.size() >= 6), 1);
      for (int i = 0; i < 6 && i < order_q.size(); i++) chk("fair_order", order_q[i], i % N);
      repeat (16) step();

`ifdef ARB_TIMEOUT_EN
      // timeout: no slave response at all
      ack_mode = 2; ack_r = 0;
      new_req(1, 1'b0);
      step();
      repeat (7) step();
      chk("to_not_yet", o_ack, 0);
      step();
      chk("to_ack", o_ack, 4'b0010); chk("to_err", o_err, 1);
      chk("to_rd", o_rd_data, 32'hDEAD_BEEF);
      step(); chk("to_idle", o_bus_en, 0);
      ack_p = 10;
`endif

      // randomized traffic with occasional violations and resets
      ack_mode = 0; auto_p = 30; viol_p = 2;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin rst_r = 1; drop_all(); end
         else rst_r = 0;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
